instr_fetch_seq: RTL and testbench
==================================

// Module: instr_fetch_seq
// PURPOSE
//  Upstream stage of the 8-bit micro: holds a small program store and drives its 8-bit
//  instruction bus, one instruction per clk. Supports run, single-step, halt and loop.
//  The micro executes every edge, so idle cycles carry NOP = 8'h30 (MR r0<-r0).
//  Program is loaded through a write port while the sequencer is not running.
// PARAMETERS
//  ADDR_W   4              program address width
//  DEPTH    1<<ADDR_W      program store entries (8 bits each)
//  NOP      8'h30          instruction driven whenever no program instruction is issued
// PORTS
//  clk          in   1         system clock
//  rst          in   1         synchronous, active-high reset
//  load_we      in   1         program write strobe
//  load_addr    in   ADDR_W    program write address
//  load_data    in   8         program write data
//  prog_len     in   ADDR_W+1  program length in instructions (sampled on start/step)
//  loop_en      in   1         1: wrap to address 0 after last instruction; 0: stop
//  start        in   1         run from address 0
//  step         in   1         issue exactly one instruction, then idle
//  halt         in   1         stop issuing at next edge
//  instruction  out  8         registered instruction to the micro
//  instr_valid  out  1         1 when instruction is a program word, not NOP fill
//  pc           out  ADDR_W    address of the word currently on instruction
//  busy         out  1         1 in RUN
//  done         out  1         1 in DONE (program completed with loop_en=0)
// BEHAVIOUR
//  - Clock and reset: single clk; rst is synchronous, active-high.
//  - Reset: state IDLE, instruction=NOP, instr_valid=0, pc=0, nxt=0, busy=0, done=0;
//    all program words cleared to NOP.
//  - Effective length L = min(prog_len, DEPTH). L==0: start/step are ignored.
//  - Internal nxt = address of next word to issue; all outputs are registered.
//  - Input priority in a cycle: halt > start > step.
//  - States IDLE, RUN, DONE:
//    IDLE : start -> RUN; next edge drives mem[0], pc=0, valid=1, nxt=1%L.
//           step  -> stays IDLE; next edge drives mem[nxt] for 1 cycle, pc=nxt, valid=1,
//                    nxt=(nxt+1)%L; following cycle reverts to NOP/valid=0 unless step again.
//    RUN  : each edge drives mem[nxt], pc=nxt, nxt advances. After issuing word L-1:
//           loop_en=1 -> the next word is mem[0] with no gap cycle;
//           loop_en=0 -> DONE: NOP, valid=0, done=1. halt -> IDLE next edge,
//           NOP, valid=0, nxt kept (step resumes there). start in RUN is ignored.
//    DONE : done stays 1 until start (-> RUN from 0) or rst; step in DONE is ignored.
//  - Latency: start asserted at edge n -> mem[0] on instruction after edge n+1.
//  - load_we: accepted in IDLE/DONE only (same cycle as start: write lands,
//    start still samples old word 0); silently dropped in RUN.
//  - nxt >= L at sampling (prog_len shrunk): nxt forced to 0 before issuing.
//  - rst mid-RUN: next edge is reset state; the micro sees NOP from that edge on.
// STRUCTURE
//  - Shared package/header micro_pkg: opcode constants (LD..XRI), NOP encoding,
//    FSM state encodings (IDLE/RUN/DONE), instruction width 8.
//  - Sub-module prog_mem: DEPTH x 8 register file, sync write, async read, sync
//    clear on rst. Sequencer FSM + nxt/pc logic stays in instr_fetch_seq.
// TESTING
//  1 Reset: assert rst 2 cycles -> instruction=8'h30, valid=0, pc=0, busy=0, done=0.
//  2 Load 8'h21,8'h44,8'h17 at 0..2, prog_len=3, loop_en=0, start pulse -> 8'h21,
//    8'h44, 8'h17 on consecutive cycles, pc 0,1,2, then NOP, valid=0, done=1.
//  3 Same program, loop_en=1, run 7 cycles -> 21,44,17,21,44,17,21 with no gap;
//    busy=1 throughout.
//  4 Halt after 2nd word, then step twice -> 8'h17 (pc=2), NOP, then 8'h21 (pc=0).
//  5 load_we to addr 0 with 8'hFF during RUN -> dropped; next loop still issues 8'h21.
//  6 rst asserted mid-RUN at pc=1 -> next cycle NOP, valid=0, busy=0;
//    memory reads back all NOP; start with prog_len=0 -> stays IDLE.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared definitions for the 8-bit micro: instruction width, opcode field
// values, the NOP fill word and the fetch sequencer state encoding.
package micro_pkg;

    localparam int unsigned INSTR_W = 8;

    // Opcodes occupy the upper nibble of an instruction word.
    localparam logic [3:0] OP_LD  = 4'h0;
    localparam logic [3:0] OP_ST  = 4'h1;
    localparam logic [3:0] OP_LDI = 4'h2;
    localparam logic [3:0] OP_MR  = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_ADI = 4'h9;
    localparam logic [3:0] OP_ANI = 4'hA;
    localparam logic [3:0] OP_ORI = 4'hB;
    localparam logic [3:0] OP_XRI = 4'hC;

    // MR r0<-r0: harmless when the micro executes it on idle cycles.
    localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_MR, 4'h0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/instr_fetch_seq_prog_mem.sv
// Program store: DEPTH x 8 register file, synchronous write, asynchronous
// read, every word cleared to CLR_WORD on synchronous reset.
module prog_mem
    import micro_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 4,
    parameter logic [INSTR_W-1:0] CLR_WORD = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];

    // Next contents: current contents with the addressed word replaced on write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: CLR_WORD};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: drives one registered instruction per clock
// from the program store, with run, single-step, halt and loop control.
// Cycles that issue no program word carry the NOP fill instruction.
module instr_fetch_seq
    import micro_pkg::*;
#(
    parameter int unsigned        ADDR_W = 4,
    parameter logic [INSTR_W-1:0] NOP    = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               loop_en,
    input  logic               start,
    input  logic               step,
    input  logic               halt,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done
);

    localparam int unsigned     DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  nxt_q, nxt_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [ADDR_W:0]    eff_len;
    logic               len_nz;
    logic [ADDR_W-1:0]  step_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic               issue;
    logic               mem_we;
    logic               last_issued;

    // Successor of address a within a program of len words.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                    input logic [ADDR_W:0]   len);
        logic [ADDR_W:0] n;
        n = {1'b0, a} + (ADDR_W + 1)'(1);
        return (n >= len) ? '0 : n[ADDR_W-1:0];
    endfunction

    // Program writes are only accepted while the sequencer is not running.
    assign mem_we = load_we && (state_q != ST_RUN);

    prog_mem #(
        .ADDR_W   (ADDR_W),
        .CLR_WORD (NOP)
    ) u_prog_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Length clamp, step resume address and end-of-pass detection.
    always_comb begin
        eff_len     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
        len_nz      = (eff_len != '0);
        step_addr   = ({1'b0, nxt_q} >= eff_len) ? '0 : nxt_q;
        last_issued = ({1'b0, pc_q} == (len_q - (ADDR_W + 1)'(1)));
    end

    // Next-state, issue address and registered output values.
    // The read uses the pre-edge store contents, so a write landing in the
    // same cycle as start does not affect the word issued by that start.
    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = NOP;
        valid_d = 1'b0;
        rd_addr = nxt_q;
        issue   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (start && len_nz) begin
                    state_d = ST_RUN;
                    len_d   = eff_len;
                    rd_addr = '0;
                    issue   = 1'b1;
                end else if (step && len_nz) begin
                    len_d   = eff_len;
                    rd_addr = step_addr;
                    issue   = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (last_issued && !loop_en) begin
                    state_d = ST_DONE;
                end else begin
                    rd_addr = nxt_q;
                    issue   = 1'b1;
                end
            end
            ST_DONE: begin
                if (!halt && start && len_nz) begin
                    state_d = ST_RUN;
                    len_d   = eff_len;
                    rd_addr = '0;
                    issue   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            instr_d = rd_data;
            valid_d = 1'b1;
            pc_d    = rd_addr;
            nxt_d   = wrap_inc(rd_addr, len_d);
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            nxt_q   <= '0;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nxt_q   <= nxt_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: a behavioural model predicts each
// cycle's outputs into a queue; a monitor pops and compares every cycle.
module tb_instr_fetch_seq;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam logic [7:0] NOPW = 8'h30;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic        clk = 1'b0;
    logic        rst, load_we, loop_en, start, step, halt;
    logic [3:0]  load_addr;
    logic [7:0]  load_data;
    logic [4:0]  prog_len;
    logic [7:0]  instruction;
    logic        instr_valid, busy, done;
    logic [3:0]  pc;

    always #5 clk = ~clk;

    instr_fetch_seq #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .loop_en     (loop_en),
        .start       (start),
        .step        (step),
        .halt        (halt),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int  instr;
        bit  valid;
        bit  chk_pc;
        int  pc;
        bit  busy;
        bit  done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc_no = 0;

    // Reference model: program as an int array, sequencer as a mode plus
    // the address of the next word and the word currently shown.
    int m_mem[DEPTH];
    int m_mode = M_IDLE;
    int m_nxt  = 0;
    int m_pc   = 0;
    int m_len  = 1;

    function automatic void model_cycle();
        exp_t e;
        int   len_now;
        int   old_mode;
        int   a;
        bit   issue;
        e.instr = NOPW; e.valid = 0; e.chk_pc = 0; e.pc = 0;
        a = 0; issue = 0;
        old_mode = m_mode;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = NOPW;
            m_mode = M_IDLE; m_nxt = 0; m_pc = 0;
            e.chk_pc = 1;
        end else begin
            len_now = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
            if (m_mode == M_RUN) begin
                if (halt) m_mode = M_IDLE;
                else if (m_pc == m_len - 1 && !loop_en) m_mode = M_DONE;
                else begin a = m_nxt; issue = 1; end
            end else if (!halt && len_now != 0) begin
                if (start) begin
                    m_mode = M_RUN; m_len = len_now; a = 0; issue = 1;
                end else if (step && m_mode == M_IDLE) begin
                    m_len = len_now; a = (m_nxt >= len_now) ? 0 : m_nxt; issue = 1;
                end
            end
            if (issue) begin
                e.instr = m_mem[a]; e.valid = 1; e.chk_pc = 1; e.pc = a;
                m_pc = a; m_nxt = (a + 1) % m_len;
            end
            if (load_we && old_mode != M_RUN) m_mem[load_addr] = int'(load_data);
        end
        e.busy = (m_mode == M_RUN);
        e.done = (m_mode == M_DONE);
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_no, act, expv);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc_no++;
            chk("instruction", int'(instruction), e.instr);
            chk("instr_valid", int'(instr_valid), int'(e.valid));
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            if (e.chk_pc) chk("pc", int'(pc), e.pc);
        end
    end

    task automatic tick();
        model_cycle();
        @(posedge clk);
        @(negedge clk);
        rst = 0; load_we = 0; start = 0; step = 0; halt = 0;
    endtask

    task automatic load(input int addr, input int data);
        load_we = 1; load_addr = 4'(addr); load_data = 8'(data);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; load_we = 0; load_addr = '0; load_data = '0; prog_len = 5'd0;
        loop_en = 0; start = 0; step = 0; halt = 0;
        @(negedge clk);

        // 1: reset for two cycles
        rst = 1; tick();
        rst = 1; tick();

        // 2: load three words, run once without loop
        load(0, 8'h21); load(1, 8'h44); load(2, 8'h17);
        prog_len = 5'd3; loop_en = 0;
        start = 1; tick();
        repeat (5) tick();

        // 3: loop for seven cycles
        loop_en = 1;
        start = 1; tick();
        repeat (6) tick();

        // 4: halt after second word, then step twice
        halt = 1; tick();
        start = 1; tick();
        tick();
        halt = 1; tick();
        step = 1; tick();
        tick();
        step = 1; tick();
        tick();

        // 5: write during RUN is dropped
        start = 1; tick();
        load(0, 8'hFF);
        repeat (6) tick();

        // 6: reset mid-run at pc=1, then read back store by stepping
        halt = 1; tick();
        start = 1; tick();
        tick();
        rst = 1; tick();
        prog_len = 5'd16;
        repeat (16) begin step = 1; tick(); end
        prog_len = 5'd0;
        start = 1; tick();
        step = 1; tick();
        tick();

        // same-cycle load and start: start sees the old word 0
        prog_len = 5'd2; loop_en = 0;
        load_we = 1; load_addr = 4'd0; load_data = 8'hA5; start = 1; tick();
        repeat (3) tick();

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 249) == 0);
            load_we = ($urandom_range(0, 3) == 0);
            load_addr = 4'($urandom_range(0, 15));
            load_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) prog_len = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 31) == 0) loop_en = ~loop_en;
            start = ($urandom_range(0, 19) == 0);
            step  = ($urandom_range(0, 7) == 0);
            halt  = ($urandom_range(0, 29) == 0);
            tick();
        end

        repeat (2) tick();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
